// File: rtl/detector_jogada.sv
// Button input stage: 2-FF sync, debounce, one-hot validation and release gating.
// Optional macro DETECTOR_JOGADA_INVALIDA_EN enables the jogada_invalida pulse.
module detector_jogada #(
  parameter int DEBOUNCE = 250000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  input  logic       limpa,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic       db_tem_jogada,
  output logic [3:0] db_estado
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRA       = 3'd1,
    REGISTRA     = 3'd2,
    SOLTA        = 3'd3,
    FILTRA_SOLTA = 3'd4
  } estado_t;

  estado_t       estado;
  logic [3:0]    sync_a;
  logic [3:0]    s_botoes;
  logic [3:0]    amostra;
  logic [CW-1:0] cnt;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a   <= 4'd0;
      s_botoes <= 4'd0;
    end else begin
      sync_a   <= botoes;
      s_botoes <= sync_a;
    end
  end

  assign db_tem_jogada = |s_botoes;
  assign db_estado     = {1'b0, estado};

  // The load into jogada is written after the limpa clear so a coincident load wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      amostra      <= 4'd0;
      cnt          <= '0;
      jogada       <= 4'd0;
      jogada_feita <= 1'b0;
`ifdef DETECTOR_JOGADA_INVALIDA_EN
      jogada_invalida <= 1'b0;
`endif
    end else begin
      jogada_feita <= 1'b0;
`ifdef DETECTOR_JOGADA_INVALIDA_EN
      jogada_invalida <= 1'b0;
`endif
      if (limpa) begin
        jogada <= 4'd0;
      end
      case (estado)
        OCIOSO: begin
          if (habilita && (s_botoes != 4'd0)) begin
            estado  <= FILTRA;
            amostra <= s_botoes;
            cnt     <= '0;
          end
        end
        FILTRA: begin
          if (s_botoes != amostra) begin
            estado <= OCIOSO;
          end else if (cnt == CNT_MAX) begin
            if (is_onehot(amostra)) begin
              estado       <= REGISTRA;
              jogada       <= amostra;
              jogada_feita <= 1'b1;
            end else begin
              estado <= SOLTA;
`ifdef DETECTOR_JOGADA_INVALIDA_EN
              jogada_invalida <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REGISTRA: begin
          estado <= SOLTA;
        end
        SOLTA: begin
          if (s_botoes == 4'd0) begin
            estado <= FILTRA_SOLTA;
            cnt    <= '0;
          end
        end
        FILTRA_SOLTA: begin
          if (s_botoes != 4'd0) begin
            estado <= SOLTA;
          end else if (cnt == CNT_MAX) begin
            estado <= OCIOSO;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

`ifndef DETECTOR_JOGADA_INVALIDA_EN
  assign jogada_invalida = 1'b0;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada (DEBOUNCE=4): vector table, directed corner cases and
// randomized stimulus against a run-length reference model.
module tb_detector_jogada;

  localparam int DEB = 4;
`ifdef DETECTOR_JOGADA_INVALIDA_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita;
  logic       limpa;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic       db_tem_jogada;
  logic [3:0] db_estado;

  detector_jogada #(.DEBOUNCE(DEB)) dut (
    .clock          (clock),
    .reset          (reset),
    .botoes         (botoes),
    .habilita       (habilita),
    .limpa          (limpa),
    .jogada         (jogada),
    .jogada_feita   (jogada_feita),
    .jogada_invalida(jogada_invalida),
    .db_tem_jogada  (db_tem_jogada),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int feita_seen = 0;
  int inv_seen = 0;

  // Model: a press is taken after DEB+1 identical sampled cycles, a release likewise.
  typedef enum {M_IDLE, M_PRESS, M_ACK, M_RELEASE} mmode_t;
  mmode_t     m_mode;
  int         m_run;
  logic [3:0] m_cand, m_s1, m_s2, m_jog;
  logic       m_feita, m_inv;

  typedef struct {
    logic [3:0] botoes;
    logic       habilita;
    logic       limpa;
    logic [3:0] exp_jogada;
    logic       exp_feita;
    logic       exp_tem;
    logic [3:0] exp_estado;
  } vec_t;
  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic h, input logic l);
    botoes   = b;
    habilita = h;
    limpa    = l;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_run = 0; m_cand = 4'd0;
    m_s1 = 4'd0; m_s2 = 4'd0; m_jog = 4'd0; m_feita = 1'b0; m_inv = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] s;
    logic load;
    if (!reset) begin
      model_reset();
      return;
    end
    s = m_s2; load = 1'b0; m_feita = 1'b0; m_inv = 1'b0;
    case (m_mode)
      M_IDLE: if (habilita && s != 4'd0) begin
        m_cand = s; m_run = 1; m_mode = M_PRESS;
      end
      M_PRESS: if (s != m_cand) begin
        m_mode = M_IDLE; m_run = 0;
      end else begin
        m_run++;
        if (m_run == DEB + 1) begin
          if ($countones(m_cand) == 1) begin
            load = 1'b1; m_feita = 1'b1; m_mode = M_ACK;
          end else begin
            m_inv = INV_EN; m_mode = M_RELEASE; m_run = 0;
          end
        end
      end
      M_ACK: begin m_mode = M_RELEASE; m_run = 0; end
      M_RELEASE: begin
        m_run = (s == 4'd0) ? m_run + 1 : 0;
        if (m_run == DEB + 1) begin m_mode = M_IDLE; m_run = 0; end
      end
      default: m_mode = M_IDLE;
    endcase
    if (load) m_jog = m_cand;
    else if (limpa) m_jog = 4'd0;
    m_s2 = m_s1;
    m_s1 = botoes;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    if (jogada_feita === 1'b1) feita_seen++;
    if (jogada_invalida === 1'b1) inv_seen++;
    checkOutput("model_jogada", jogada, m_jog);
    checkOutput("model_feita", {3'd0, jogada_feita}, {3'd0, m_feita});
    checkOutput("model_invalida", {3'd0, jogada_invalida}, {3'd0, m_inv});
    checkOutput("model_tem", {3'd0, db_tem_jogada}, {3'd0, |m_s2});
  endtask

  task automatic hold(input logic [3:0] b, input logic h, input int n);
    applyStimulus(b, h, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic vec_t mk(input logic [3:0] b, input logic l, input logic [3:0] j,
                              input logic f, input logic t, input logic [3:0] e);
    vec_t v;
    v.botoes = b; v.habilita = 1'b1; v.limpa = l;
    v.exp_jogada = j; v.exp_feita = f; v.exp_tem = t; v.exp_estado = e;
    return v;
  endfunction

  initial begin
    int f0, i0, nseg, len;
    logic [3:0] val;
    logic hab;
    logic glitch_ok;
    logic [3:0] glitch[12];

    vecs[0]  = mk(4'b0100, 0, 4'h0, 0, 0, 4'd0);
    vecs[1]  = mk(4'b0100, 0, 4'h0, 0, 1, 4'd0);
    vecs[2]  = mk(4'b0100, 0, 4'h0, 0, 1, 4'd1);
    vecs[3]  = mk(4'b0100, 0, 4'h0, 0, 1, 4'd1);
    vecs[4]  = mk(4'b0100, 0, 4'h0, 0, 1, 4'd1);
    vecs[5]  = mk(4'b0100, 0, 4'h0, 0, 1, 4'd1);
    vecs[6]  = mk(4'b0100, 0, 4'h4, 1, 1, 4'd2);
    vecs[7]  = mk(4'b0100, 0, 4'h4, 0, 1, 4'd3);
    vecs[8]  = mk(4'b0100, 0, 4'h4, 0, 1, 4'd3);
    vecs[9]  = mk(4'b0100, 0, 4'h4, 0, 1, 4'd3);
    vecs[10] = mk(4'b0000, 0, 4'h4, 0, 1, 4'd3);
    vecs[11] = mk(4'b0000, 0, 4'h4, 0, 0, 4'd3);
    vecs[12] = mk(4'b0000, 0, 4'h4, 0, 0, 4'd4);
    vecs[13] = mk(4'b0000, 0, 4'h4, 0, 0, 4'd4);
    vecs[14] = mk(4'b0000, 0, 4'h4, 0, 0, 4'd4);
    vecs[15] = mk(4'b0000, 0, 4'h4, 0, 0, 4'd4);
    vecs[16] = mk(4'b0000, 0, 4'h4, 0, 0, 4'd0);
    vecs[17] = mk(4'b0000, 1, 4'h0, 0, 0, 4'd0);

    reset = 1'b0;
    applyStimulus(4'd0, 1'b0, 1'b0);
    model_reset();
    tick();
    tick();
    checkOutput("reset_estado", db_estado, 4'd0);
    reset = 1'b1;

    // Clean press of 0100, hold, release, then limpa
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].botoes, vecs[i].habilita, vecs[i].limpa);
      tick();
      checkOutput($sformatf("vec%0d_jogada", i), jogada, vecs[i].exp_jogada);
      checkOutput($sformatf("vec%0d_feita", i), {3'd0, jogada_feita}, {3'd0, vecs[i].exp_feita});
      checkOutput($sformatf("vec%0d_tem", i), {3'd0, db_tem_jogada}, {3'd0, vecs[i].exp_tem});
      checkOutput($sformatf("vec%0d_estado", i), db_estado, vecs[i].exp_estado);
    end
    applyStimulus(4'd0, 1'b1, 1'b0);

    // Bouncing press, then stable hold
    f0 = feita_seen;
    for (int k = 0; k < 4; k++) begin
      hold(4'b0100, 1'b1, 2);
      hold(4'b0000, 1'b1, 2);
    end
    checkOutput("bounce_no_pulse", 4'(feita_seen - f0), 4'd0);
    hold(4'b0100, 1'b1, 14);
    checkOutput("bounce_one_pulse", 4'(feita_seen - f0), 4'd1);
    checkOutput("bounce_jogada", jogada, 4'b0100);

    // Glitchy release with stray 0001 presses: must stay in release states
    glitch = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
    f0 = feita_seen;
    glitch_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      hold(glitch[k], 1'b1, 1);
      if (db_estado != 4'd3 && db_estado != 4'd4) glitch_ok = 1'b0;
    end
    checkOutput("glitch_stays_release", {3'd0, glitch_ok}, 4'd1);
    hold(4'b0000, 1'b1, 8);
    checkOutput("release_idle", db_estado, 4'd0);
    hold(4'b0001, 1'b1, 10);
    checkOutput("after_release_pulse", 4'(feita_seen - f0), 4'd1);
    checkOutput("after_release_jogada", jogada, 4'b0001);
    hold(4'b0000, 1'b1, 10);

    // Multi-button press is dropped
    f0 = feita_seen;
    i0 = inv_seen;
    hold(4'b0011, 1'b1, 12);
    checkOutput("invalid_no_pulse", 4'(feita_seen - f0), 4'd0);
    checkOutput("invalid_jogada", jogada, 4'b0001);
    checkOutput("invalid_flag_count", 4'(inv_seen - i0), {3'd0, INV_EN});
    hold(4'b0000, 1'b1, 10);

    // Press held while habilita=0, then enabled; limpa collides with the load
    f0 = feita_seen;
    hold(4'b0010, 1'b0, 20);
    checkOutput("hab0_no_pulse", 4'(feita_seen - f0), 4'd0);
    checkOutput("hab0_estado", db_estado, 4'd0);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("hab1_edge%0d_feita", k), {3'd0, jogada_feita}, 4'd0);
    end
    applyStimulus(4'b0010, 1'b1, 1'b1);
    tick();
    checkOutput("hab1_edge5_feita", {3'd0, jogada_feita}, 4'd1);
    checkOutput("limpa_vs_load", jogada, 4'b0010);
    hold(4'b0000, 1'b1, 10);

    // Asynchronous reset while filtering
    hold(4'b1000, 1'b1, 5);
    checkOutput("pre_reset_filtra", db_estado, 4'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rst_jogada", jogada, 4'd0);
    checkOutput("async_rst_estado", db_estado, 4'd0);
    checkOutput("async_rst_feita", {3'd0, jogada_feita}, 4'd0);
    checkOutput("async_rst_tem", {3'd0, db_tem_jogada}, 4'd0);
    model_reset();
    tick();
    reset = 1'b1;
    f0 = feita_seen;
    hold(4'b1000, 1'b1, 10);
    checkOutput("post_reset_pulse", 4'(feita_seen - f0), 4'd1);
    checkOutput("post_reset_jogada", jogada, 4'b1000);
    hold(4'b0000, 1'b1, 10);

    // Randomized segments against the model
    nseg = 60;
    for (int s = 0; s < nseg; s++) begin
      case ($urandom_range(0, 3))
        0: val = 4'd0;
        1, 2: val = 4'(1 << $urandom_range(0, 3));
        default: val = 4'($urandom_range(0, 15));
      endcase
      hab = ($urandom_range(0, 4) != 0);
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        applyStimulus(val, hab, ($urandom_range(0, 7) == 0));
        tick();
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
